// File: rtl/gnn_sched_pkg.sv
// Shared types and helpers for the GNN combination scheduler.
package gnn_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

   localparam int MAX_MEM_LATENCY = 4;

   function automatic int idx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/combination_scheduler_loop_counter.sv
// Wrapping index counter: counts 0..LAST_COUNT while enabled; clear overrides enable.
module loop_counter #(
   parameter int LAST_COUNT = 1,
   parameter int W          = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         last
);

   assign last = (count == W'(LAST_COUNT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= last ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/combination_scheduler.sv
// Sequences feature/weight reads per node, steers the MAC and hands off node results.
module combination_scheduler
   import gnn_sched_pkg::*;
#(
   parameter int NUM_NODES    = 4,
   parameter int NUM_FEATURES = 3,
   parameter int MEM_LATENCY  = 2,
   localparam int NODE_W = idx_w(NUM_NODES),
   localparam int FEAT_W = idx_w(NUM_FEATURES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_read_en,
   output logic [FEAT_W-1:0] feature_addr,
   output logic [NODE_W-1:0] node_addr,
   output logic              mac_clear,
   output logic              mac_enable,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [NODE_W-1:0] result_node
);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_ISSUE = ISSUE;
   localparam logic [2:0] S_DRAIN = DRAIN;
   localparam logic [2:0] S_WRITE = WRITE;
   localparam logic [2:0] S_DONE  = DONE;

   localparam int DRAIN_W = $clog2(MAX_MEM_LATENCY);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LATENCY - 1);

   logic [2:0]         state;
   logic [2:0]         state_next;
   logic [FEAT_W-1:0]  feat_cnt;
   logic [NODE_W-1:0]  node_cnt;
   logic               feat_last;
   logic               node_last;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [MEM_LATENCY-1:0] en_sr;
   logic [MEM_LATENCY-1:0] clr_sr;
   logic               handshake;

   assign handshake = (state == S_WRITE) && result_ready;

   loop_counter #(.LAST_COUNT(NUM_FEATURES - 1), .W(FEAT_W)) u_feat_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (state == S_ISSUE),
      .clear  (state != S_ISSUE),
      .count  (feat_cnt),
      .last   (feat_last)
   );

   loop_counter #(.LAST_COUNT(NUM_NODES - 1), .W(NODE_W)) u_node_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (handshake),
      .clear  (state == S_IDLE),
      .count  (node_cnt),
      .last   (node_last)
   );

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_ISSUE;
         S_ISSUE: if (feat_last) state_next = S_DRAIN;
         S_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = S_WRITE;
         S_WRITE: if (result_ready) state_next = node_last ? S_DONE : S_ISSUE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // DRAIN waits out the memory latency so the last read lands before WRITE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         drain_cnt <= '0;
      else if (state == S_DRAIN)
         drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
      else
         drain_cnt <= '0;
   end

   // Read strobe and first-feature flag travel with the data through the memory pipe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_sr  <= '0;
         clr_sr <= '0;
      end else begin
         en_sr[0]  <= mem_read_en;
         clr_sr[0] <= mem_read_en && (feature_addr == '0);
         for (int i = 1; i < MEM_LATENCY; i++) begin
            en_sr[i]  <= en_sr[i-1];
            clr_sr[i] <= clr_sr[i-1];
         end
      end
   end

   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign mem_read_en  = (state == S_ISSUE);
   assign feature_addr = (state == S_ISSUE) ? feat_cnt : '0;
   assign node_addr    = (state == S_ISSUE || state == S_DRAIN || state == S_WRITE) ? node_cnt : '0;
   assign result_valid = (state == S_WRITE);
   assign result_node  = (state == S_WRITE) ? node_cnt : '0;
   assign mac_enable   = en_sr[MEM_LATENCY-1];
   assign mac_clear    = clr_sr[MEM_LATENCY-1];

endmodule
